// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and index helpers for the round-robin Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_MASTERS = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Grants are one-hot, so OR-ing the indices of set bits yields the index
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - packed N-master / 1-slave Wishbone bundle with arbiter, master and slave views
interface wb_rr_arbiter_if #(
  parameter int unsigned N_MASTERS     = 2,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
);
  localparam int unsigned SW = WB_DATA_WIDTH / 8;

  logic [N_MASTERS-1:0]               m_cyc;
  logic [N_MASTERS-1:0]               m_stb;
  logic [N_MASTERS-1:0]               m_we;
  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_adr;
  logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_w;
  logic [N_MASTERS*SW-1:0]            m_sel;
  logic [WB_DATA_WIDTH-1:0]           m_dat_r;
  logic [N_MASTERS-1:0]               m_ack;
  logic [N_MASTERS-1:0]               m_err;

  logic                               s_cyc;
  logic                               s_stb;
  logic                               s_we;
  logic [WB_ADDR_WIDTH-1:0]           s_adr;
  logic [WB_DATA_WIDTH-1:0]           s_dat_w;
  logic [SW-1:0]                      s_sel;
  logic [WB_DATA_WIDTH-1:0]           s_dat_r;
  logic                               s_ack;
  logic                               s_err;

  modport arb (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack, s_err,
    output m_dat_r, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
    input  m_dat_r, m_ack, m_err
  );

  modport slave (
    input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
    output s_dat_r, s_ack, s_err
  );

endinterface

// File: rtl/wb_rr_arb_pick.sv
// rtl/wb_rr_arb_pick.sv - combinational round-robin pick: first requester strictly after ptr, wrapping
module wb_rr_arb_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] k;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    // Offset 1..N visits every master once, ending at ptr itself for the lone-requester case
    for (int unsigned i = 1; i <= N; i++) begin
      k = IW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N:1 Wishbone classic round-robin arbiter, grant held for the whole CYC
// Optional slave-response watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS     = 2,
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  wb_rr_arbiter_if.arb         bus,
  output logic [N_MASTERS-1:0] gnt
);

  localparam int unsigned IW = idx_width(N_MASTERS);
  localparam int unsigned SW = WB_DATA_WIDTH / 8;

  arb_state_e           state_q;
  logic [N_MASTERS-1:0] gnt_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        gidx;
  logic                 active;
  logic                 timeout;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  wb_rr_arb_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i   (bus.m_cyc),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign gidx   = IW'(onehot_to_idx(16'(gnt_q)));
  // Reset gates the datapath immediately so an aborted master sees no response
  assign active = rstn && (gnt_q != '0);
  assign gnt    = gnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(N_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_gnt;
            ptr_q   <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.m_cyc[gidx]) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt_q;

  assign timeout = active && (wd_cnt_q == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rstn || state_q == IDLE || bus.s_ack || bus.s_err || timeout) begin
      wd_cnt_q <= '0;
    end else if (bus.m_stb[gidx]) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_w = '0;
    bus.s_sel   = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    if (active) begin
      bus.s_cyc       = bus.m_cyc[gidx];
      bus.s_stb       = bus.m_stb[gidx] & ~timeout;
      bus.s_we        = bus.m_we[gidx];
      bus.s_adr       = bus.m_adr[gidx*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
      bus.s_dat_w     = bus.m_dat_w[gidx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      bus.s_sel       = bus.m_sel[gidx*SW +: SW];
      bus.m_ack[gidx] = bus.s_ack;
      bus.m_err[gidx] = bus.s_err | timeout;
    end
  end

  assign bus.m_dat_r = bus.s_dat_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - vector table plus hand sequences, slave-side transfer scoreboard
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] gnt;

  wb_rr_arbiter_if #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus();

  wb_rr_arbiter #(
    .N_MASTERS     (N),
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT       (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .gnt  (gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic [3:0] x_gnt;
    logic       x_scyc;
    logic       x_sstb;
    logic [3:0] x_ack;
    logic [3:0] x_err;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } xfer_t;

  xfer_t       sb_q[$];
  xfer_t       mon_x;
  vec_t        vecs[26];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sdr;

  function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [3:0] s,
                              input logic a, input logic e, input logic [3:0] g,
                              input logic sc, input logic ss, input logic [3:0] ma,
                              input logic [3:0] me);
    vec_t v;
    v.r = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e;
    v.x_gnt = g; v.x_scyc = sc; v.x_sstb = ss; v.x_ack = ma; v.x_err = me;
    return v;
  endfunction

  function automatic xfer_t master_xfer(input int i);
    xfer_t x;
    x.adr = 32'(32'h100 * (i + 1));
    x.dat = 32'(32'hDEADBEEF + 32'h01010101 * i);
    x.we  = ((i % 2) == 0);
    x.sel = (i == 1) ? 4'h3 : 4'hF;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] c, input logic [3:0] s,
                      input logic a, input logic e, input int push);
    @(posedge clk);
    #1;
    rstn        = r;
    bus.m_cyc   = c;
    bus.m_stb   = s;
    bus.s_ack   = a;
    bus.s_err   = e;
    sdr         = $urandom;
    bus.s_dat_r = sdr;
    if (push >= 0) sb_q.push_back(master_xfer(push));
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.s_cyc && bus.s_stb && bus.s_ack) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_unexpected: got transfer adr %0h expected none", bus.s_adr);
      end else begin
        mon_x = sb_q.pop_front();
        chk("sb_adr", bus.s_adr, mon_x.adr);
        chk("sb_dat_w", bus.s_dat_w, mon_x.dat);
        chk("sb_we", 32'(bus.s_we), 32'(mon_x.we));
        chk("sb_sel", 32'(bus.s_sel), 32'(mon_x.sel));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int pidx;
    logic [3:0] x_err_w;
    logic       x_stb_w;

    bus.m_cyc = '0; bus.m_stb = '0; bus.s_ack = 1'b0; bus.s_err = 1'b0;
    bus.s_dat_r = '0;
    for (int i = 0; i < int'(N); i++) begin
      xfer_t x;
      x = master_xfer(i);
      bus.m_adr[i*AW +: AW]   = x.adr;
      bus.m_dat_w[i*DW +: DW] = x.dat;
      bus.m_we[i]             = x.we;
      bus.m_sel[i*4 +: 4]     = x.sel;
    end

    // rstn cyc stb ack err | gnt s_cyc s_stb m_ack m_err
    vecs[0]  = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[1]  = mk(0, 4'b0001, 4'b0001, 1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[2]  = mk(1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[3]  = mk(1, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    vecs[4]  = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    vecs[5]  = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[6]  = mk(1, 4'b0011, 4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[7]  = mk(1, 4'b0011, 4'b0011, 1, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
    vecs[8]  = mk(1, 4'b0001, 4'b0001, 1, 0, 4'b0010, 0, 0, 4'b0010, 4'b0000);
    vecs[9]  = mk(1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[10] = mk(1, 4'b0001, 4'b0001, 1, 0, 4'b0001, 1, 1, 4'b0001, 4'b0000);
    vecs[11] = mk(1, 4'b0001, 4'b0000, 0, 1, 4'b0001, 1, 0, 4'b0000, 4'b0001);
    vecs[12] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    vecs[13] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[14] = mk(1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[15] = mk(1, 4'b1101, 4'b1101, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
    vecs[16] = mk(1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[17] = mk(1, 4'b1011, 4'b1011, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000);
    vecs[18] = mk(1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[19] = mk(1, 4'b0111, 4'b0111, 0, 0, 4'b1000, 0, 0, 4'b0000, 4'b0000);
    vecs[20] = mk(1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[21] = mk(1, 4'b1110, 4'b1110, 0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
    vecs[22] = mk(1, 4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    vecs[23] = mk(1, 4'b1111, 4'b1111, 1, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
    vecs[24] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
    vecs[25] = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);

    for (int k = 0; k < 26; k++) begin
      pidx = -1;
      if (vecs[k].ack && vecs[k].x_sstb) begin
        for (int j = 0; j < 4; j++) if (vecs[k].x_gnt[j]) pidx = j;
      end
      step(vecs[k].r, vecs[k].cyc, vecs[k].stb, vecs[k].ack, vecs[k].err, pidx);
      chk($sformatf("r%0d_gnt", k), 32'(gnt), 32'(vecs[k].x_gnt));
      chk($sformatf("r%0d_s_cyc", k), 32'(bus.s_cyc), 32'(vecs[k].x_scyc));
      chk($sformatf("r%0d_s_stb", k), 32'(bus.s_stb), 32'(vecs[k].x_sstb));
      chk($sformatf("r%0d_m_ack", k), 32'(bus.m_ack), 32'(vecs[k].x_ack));
      chk($sformatf("r%0d_m_err", k), 32'(bus.m_err), 32'(vecs[k].x_err));
      chk($sformatf("r%0d_m_dat_r", k), bus.m_dat_r, sdr);
    end

    // Burst lock: m1 alone, then m0 joins while m1 runs four acked beats
    step(1, 4'b0010, 4'b0000, 0, 0, -1);
    chk("burst_idle_gnt", 32'(gnt), 32'h0);
    for (int b = 0; b < 4; b++) begin
      step(1, 4'b0011, 4'b0011, 1, 0, 1);
      chk($sformatf("burst%0d_gnt", b), 32'(gnt), 32'b0010);
      chk($sformatf("burst%0d_m_ack", b), 32'(bus.m_ack), 32'b0010);
    end
    step(1, 4'b0001, 4'b0001, 1, 0, -1);
    chk("burst_drop_m_ack", 32'(bus.m_ack), 32'b0010);
    step(1, 4'b0001, 4'b0001, 0, 0, -1);
    chk("burst_dead_gnt", 32'(gnt), 32'h0);
    step(1, 4'b0001, 4'b0001, 1, 0, 0);
    chk("burst_m0_gnt", 32'(gnt), 32'b0001);
    chk("burst_m0_ack", 32'(bus.m_ack), 32'b0001);
    step(1, 4'b0000, 4'b0000, 0, 0, -1);
    step(1, 4'b0000, 4'b0000, 0, 0, -1);

    // Reset while m2 is mid-transfer
    step(1, 4'b0100, 4'b0000, 0, 0, -1);
    step(1, 4'b0100, 4'b0100, 0, 0, -1);
    chk("rst_m2_gnt", 32'(gnt), 32'b0100);
    chk("rst_m2_s_stb", 32'(bus.s_stb), 32'h1);
    step(0, 4'b0100, 4'b0100, 1, 0, -1);
    chk("rst_asserted_s_cyc", 32'(bus.s_cyc), 32'h0);
    chk("rst_asserted_m_ack", 32'(bus.m_ack), 32'h0);
    step(1, 4'b1111, 4'b0000, 0, 0, -1);
    chk("rst_after_gnt", 32'(gnt), 32'h0);
    chk("rst_after_s_cyc", 32'(bus.s_cyc), 32'h0);
    step(1, 4'b1111, 4'b0000, 0, 0, -1);
    chk("rst_first_gnt", 32'(gnt), 32'b0001);
    step(1, 4'b1110, 4'b0000, 0, 0, -1);
    step(1, 4'b1110, 4'b0000, 0, 0, -1);
    chk("rst_dead_gnt", 32'(gnt), 32'h0);
    step(1, 4'b1110, 4'b0000, 0, 0, -1);
    chk("rst_second_gnt", 32'(gnt), 32'b0010);
    step(1, 4'b0000, 4'b0000, 0, 0, -1);
    step(1, 4'b0000, 4'b0000, 0, 0, -1);

    // Slave never responds to m3
    step(1, 4'b1000, 4'b1000, 0, 0, -1);
    chk("wd_idle_gnt", 32'(gnt), 32'h0);
    for (int c = 1; c <= 12; c++) begin
      step(1, 4'b1000, 4'b1000, 0, 0, -1);
`ifdef WB_ARB_TIMEOUT_EN
      x_err_w = (c == int'(TO) + 1) ? 4'b1000 : 4'b0000;
      x_stb_w = (c != int'(TO) + 1);
`else
      x_err_w = 4'b0000;
      x_stb_w = 1'b1;
`endif
      chk($sformatf("wd%0d_gnt", c), 32'(gnt), 32'b1000);
      chk($sformatf("wd%0d_m_err", c), 32'(bus.m_err), 32'(x_err_w));
      chk($sformatf("wd%0d_s_stb", c), 32'(bus.s_stb), 32'(x_stb_w));
    end
    step(1, 4'b0000, 4'b0000, 0, 0, -1);
    step(1, 4'b0000, 4'b0000, 0, 0, -1);
    chk("wd_release_gnt", 32'(gnt), 32'h0);

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone classic-cycle arbiter with round-robin fairness.
- Shares one Wishbone slave (e.g. a wb slave BFM or memory model) among multiple Wishbone masters in testbench and SoC fabrics.
- Grant is held for the whole CYC assertion, so bursts and read-modify-write sequences are never split.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..16)
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width; SEL width = WB_DATA_WIDTH/8
- TIMEOUT, 256, slave-response watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- m_cyc  in  N_MASTERS  per-master CYC
- m_stb  in  N_MASTERS  per-master STB
- m_we  in  N_MASTERS  per-master WE
- m_adr  in  N_MASTERS*WB_ADDR_WIDTH  packed addresses, master i at [i*AW +: AW]
- m_dat_w  in  N_MASTERS*WB_DATA_WIDTH  packed write data
- m_sel  in  N_MASTERS*WB_DATA_WIDTH/8  packed byte selects
- m_dat_r  out  WB_DATA_WIDTH  read data, broadcast to all masters
- m_ack  out  N_MASTERS  per-master ACK
- m_err  out  N_MASTERS  per-master ERR
- s_cyc, s_stb, s_we  out  1  slave-side controls
- s_adr  out  WB_ADDR_WIDTH  slave address
- s_dat_w  out  WB_DATA_WIDTH  slave write data
- s_sel  out  WB_DATA_WIDTH/8  slave byte selects
- s_dat_r  in  WB_DATA_WIDTH  slave read data
- s_ack, s_err  in  1  slave responses
- gnt  out  N_MASTERS  one-hot current grant, 0 when idle

Behaviour:
Reset (rstn=0 at posedge):
- state=IDLE, gnt=0, last-grant pointer=N_MASTERS-1, so master 0 wins first.
- All s_* controls and all m_ack/m_err read 0 while reset is asserted or gnt=0.
- Reset mid-transfer drops the grant immediately; no response is delivered to the aborted master.

State machine:
- IDLE: if any m_cyc=1 at posedge, pick the lowest index strictly above the pointer that has m_cyc=1, wrapping modulo N_MASTERS. Register gnt, update the pointer, go to BUSY.
- Grant latency is exactly 1 cycle from the first m_cyc sample to s_cyc=1.
- BUSY: hold gnt while the granted m_cyc=1.
  - When the granted m_cyc=0 at posedge, clear gnt and go to IDLE.
  - There is one dead cycle before the next grant, even if others are waiting.

Datapath (combinational from gnt, g = granted index):
- s_cyc=m_cyc[g], s_stb=m_stb[g]; s_we/s_adr/s_dat_w/s_sel muxed from master g.
- m_ack[g]=s_ack, m_err[g]=s_err; every other bit is 0.
- m_dat_r=s_dat_r, unconditionally.
- With gnt=0, the s_* outputs are all 0.

Boundary conditions:
- Simultaneous requests: round-robin order relative to the pointer; a lone requester is re-granted on its next request.
- A master dropping m_cyc while s_ack=1 in the same cycle: that ack is still routed (combinational), then release.
- s_ack or s_err while s_stb=0: passed through, no state effect.
- Non-granted masters' m_stb/m_cyc are ignored; they are never acked.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on every s_ack|s_err.
  - It increments each BUSY cycle with s_stb=1 and no response.
  - When it reaches TIMEOUT, for one cycle: m_err[g]=1, s_stb forced 0, counter cleared. Grant is retained; the master ends the cycle normally.
- Undefined: no counter; errors come only from s_err.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, BUSY}
  - function clog2-based index width
  - a onehot-to-index function
- Sub-module wb_rr_arb_pick: combinational round-robin selector.
  - Inputs: req[N], ptr index.
  - Outputs: gnt one-hot, gnt index, valid.
- Top: FSM, pointer register, muxes, optional watchdog.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x100 → s_cyc rises 1 cycle after m_cyc; slave s_ack → m_ack[0]=1 only; gnt=01 then 00.
- Contention: m0 and m1 both assert m_cyc on the same cycle after reset → m0 granted first; after m0 releases, m1 granted following one dead cycle.
- Fairness: N=4, all four masters requesting continuously → grant order 0,1,2,3,0; no master granted twice before all others are served.
- Burst lock: m1 holds CYC across 4 STB beats while m0 requests → all 4 s_ack go to m1; m0 gets no ack until m1 drops CYC.
- Reset mid-transfer: rstn=0 while m2 is BUSY with s_stb=1 → next cycle gnt=0 and s_cyc=0; after reset, simultaneous requests are granted to m0 first.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=8): slave never acks → m_err[g] pulses exactly 8 BUSY-stb cycles after s_stb, with s_stb=0 in that cycle.
